// File: rtl/slow_clk_period_meter.sv
// slow_clk_period_meter
// Measures the period and high time of a slow asynchronous square wave in
// units of clk. A one-cycle period_valid strobe marks each new measurement.
// Loss of signal is flagged when no rising edge arrives for TIMEOUT cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | not armed; counter held at 0, waiting for a rising edge
// MEASURE | armed; counting clk cycles since the last acted-on rising edge
module slow_clk_period_meter #(
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 10_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_in,
  output logic [CNT_W-1:0] period_cycles,
  output logic [CNT_W-1:0] high_cycles,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic             prev;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_reg;

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= slow_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;
  assign fall = ~s2 & prev;

  // Measurement FSM: counter, captured high time and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      high_reg      <= '0;
      period_cycles <= '0;
      high_cycles   <= '0;
      period_valid  <= 1'b0;
      locked        <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rise) begin
            state <= MEASURE;
          end
        end
        MEASURE: begin
          // cnt is one behind the number of elapsed cycles, hence the +1.
          if (fall) begin
            high_reg <= cnt + ONE;
          end
          // A rise on the timeout cycle still counts as a valid period.
          if (rise) begin
            period_cycles <= cnt + ONE;
            high_cycles   <= high_reg;
            period_valid  <= 1'b1;
            locked        <= 1'b1;
            timeout       <= 1'b0;
            cnt           <= '0;
          end else if (cnt == TO_LAST) begin
            state   <= IDLE;
            locked  <= 1'b0;
            timeout <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slow_clk_period_meter.sv
// Testbench for slow_clk_period_meter. Waveforms are described as lists of
// (high, low) segment lengths in clk cycles; the expected reports follow
// directly from those lengths, independent of the pipeline inside the DUT.
module tb_slow_clk_period_meter;

  localparam int CNT_W   = 24;
  localparam int TIMEOUT = 100;

  logic             clk;
  logic             rst_n;
  logic             slow_in;
  logic [CNT_W-1:0] period_cycles;
  logic [CNT_W-1:0] high_cycles;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int period;
    int high;
    int cyc;
  } pulse_t;

  pulse_t got[$];
  pulse_t exp_q[$];
  int     hq[$];
  int     lq[$];

  slow_clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .slow_in      (slow_in),
    .period_cycles(period_cycles),
    .high_cycles  (high_cycles),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe; sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (rst_n && period_valid)
      got.push_back('{int'(period_cycles), int'(high_cycles), cyc});
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    slow_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    got.delete();
  endtask

  // Drive the (hq, lq) segments, optionally ending with one more rising edge
  // so the last full period also gets reported.
  task automatic drive_seq(input bit final_rise);
    for (int i = 0; i < hq.size(); i++) begin
      for (int k = 0; k < hq[i]; k++) begin
        slow_in = 1'b1;
        @(negedge clk);
      end
      for (int k = 0; k < lq[i]; k++) begin
        slow_in = 1'b0;
        @(negedge clk);
      end
    end
    if (final_rise) begin
      slow_in = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  // Reference: the first rise only arms; each later rise reports the
  // period that just ended, spaced from the previous report by that period.
  function automatic void build_expected(input bit final_rise);
    int n;
    exp_q.delete();
    n = final_rise ? hq.size() : hq.size() - 1;
    for (int i = 0; i < n; i++)
      exp_q.push_back('{hq[i] + lq[i], hq[i], 0});
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    slow_in = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({period_cycles, high_cycles, period_valid, locked, timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got p=%0d h=%0d v=%b l=%b t=%b, need all 0",
               period_cycles, high_cycles, period_valid, locked, timeout);
    end
    slow_in = 1'b0;
    rst_n   = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (locked !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got locked=%b timeout=%b, need 0 0", locked, timeout);
    end
  endtask

  task automatic test_basic();
    do_reset();
    hq = '{8, 8, 8, 8, 8};
    lq = '{12, 12, 12, 12, 12};
    drive_seq(1'b0);
    build_expected(1'b0);
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL basic_count: got %0d pulses, need %0d", got.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_tests++;
        if (got[i].period !== exp_q[i].period || got[i].high !== exp_q[i].high) begin
          n_fail++;
          $display("FAIL basic_value[%0d]: got %0d/%0d, need %0d/%0d", i,
                   got[i].period, got[i].high, exp_q[i].period, exp_q[i].high);
        end
        if (i > 0) begin
          n_tests++;
          if (got[i].cyc - got[i-1].cyc !== exp_q[i].period) begin
            n_fail++;
            $display("FAIL basic_spacing[%0d]: got %0d, need %0d", i,
                     got[i].cyc - got[i-1].cyc, exp_q[i].period);
          end
        end
      end
    end
    n_tests++;
    if (locked !== 1'b1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_flags: got locked=%b timeout=%b, need 1 0", locked, timeout);
    end
  endtask

  task automatic test_random();
    do_reset();
    hq.delete();
    lq.delete();
    for (int i = 0; i < 12; i++) begin
      hq.push_back(int'($urandom_range(45, 2)));
      lq.push_back(int'($urandom_range(45, 2)));
    end
    drive_seq(1'b1);
    build_expected(1'b1);
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d pulses, need %0d", got.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_tests++;
        if (got[i].period !== exp_q[i].period || got[i].high !== exp_q[i].high) begin
          n_fail++;
          $display("FAIL random_value[%0d]: got %0d/%0d, need %0d/%0d", i,
                   got[i].period, got[i].high, exp_q[i].period, exp_q[i].high);
        end
        if (i > 0) begin
          n_tests++;
          if (got[i].cyc - got[i-1].cyc !== exp_q[i].period) begin
            n_fail++;
            $display("FAIL random_spacing[%0d]: got %0d, need %0d", i,
                     got[i].cyc - got[i-1].cyc, exp_q[i].period);
          end
        end
      end
    end
    n_tests++;
    if (locked !== 1'b1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL random_flags: got locked=%b timeout=%b, need 1 0", locked, timeout);
    end
  endtask

  // Period equal to TIMEOUT: every rise lands on the timeout cycle and wins.
  task automatic test_period_at_timeout();
    do_reset();
    hq = '{50, 50, 50};
    lq = '{50, 50, 50};
    drive_seq(1'b1);
    n_tests++;
    if (got.size() != 3) begin
      n_fail++;
      $display("FAIL edge_count: got %0d pulses, need 3", got.size());
    end else begin
      foreach (got[i]) begin
        n_tests++;
        if (got[i].period !== TIMEOUT || got[i].high !== 50) begin
          n_fail++;
          $display("FAIL edge_value[%0d]: got %0d/%0d, need %0d/50", i,
                   got[i].period, got[i].high, TIMEOUT);
        end
        if (i > 0) begin
          n_tests++;
          if (got[i].cyc - got[i-1].cyc !== TIMEOUT) begin
            n_fail++;
            $display("FAIL edge_spacing[%0d]: got %0d, need %0d", i,
                     got[i].cyc - got[i-1].cyc, TIMEOUT);
          end
        end
      end
    end
    n_tests++;
    if (locked !== 1'b1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_flags: got locked=%b timeout=%b, need 1 0", locked, timeout);
    end
  endtask

  // Period one longer than TIMEOUT: every rise only re-arms.
  task automatic test_period_over_timeout();
    do_reset();
    hq = '{50, 50, 50, 50};
    lq = '{51, 51, 51, 51};
    drive_seq(1'b1);
    n_tests++;
    if (got.size() != 0 || timeout !== 1'b1 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL over_timeout: got pulses=%0d timeout=%b locked=%b, need 0 1 0",
               got.size(), timeout, locked);
    end
  endtask

  task automatic test_timeout();
    int t0;
    int hit;
    do_reset();
    hq = '{8, 8, 8};
    lq = '{12, 12, 12};
    drive_seq(1'b0);
    n_tests++;
    if (got.size() != 2) begin
      n_fail++;
      $display("FAIL to_pulses: got %0d pulses, need 2", got.size());
      return;
    end
    t0  = got[$].cyc;
    hit = -1;
    for (int i = 0; i < 3 * TIMEOUT; i++) begin
      if (timeout === 1'b1) begin
        hit = cyc;
        break;
      end
      @(negedge clk);
    end
    n_tests++;
    if (hit - t0 !== TIMEOUT) begin
      n_fail++;
      $display("FAIL to_delay: got %0d cycles (-1 start means none), need %0d",
               hit - t0, TIMEOUT);
    end
    n_tests++;
    if (locked !== 1'b0 || period_cycles !== 20 || high_cycles !== 8) begin
      n_fail++;
      $display("FAIL to_hold: got locked=%b p=%0d h=%0d, need 0 20 8",
               locked, period_cycles, high_cycles);
    end
    got.delete();
    hq = '{8};
    lq = '{12};
    drive_seq(1'b0);
    n_tests++;
    if (got.size() != 0 || timeout !== 1'b1 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL to_rearm: got pulses=%0d timeout=%b locked=%b, need 0 1 0",
               got.size(), timeout, locked);
    end
    slow_in = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (got.size() != 1 || timeout !== 1'b0 || locked !== 1'b1 ||
        period_cycles !== 20 || high_cycles !== 8) begin
      n_fail++;
      $display("FAIL to_recover: got pulses=%0d t=%b l=%b p=%0d h=%0d, need 1 0 1 20 8",
               got.size(), timeout, locked, period_cycles, high_cycles);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    hq = '{8, 8};
    lq = '{12, 12};
    drive_seq(1'b0);
    slow_in = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({period_cycles, high_cycles, period_valid, locked, timeout} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got p=%0d h=%0d v=%b l=%b t=%b, need all 0",
               period_cycles, high_cycles, period_valid, locked, timeout);
    end
    rst_n = 1'b1;
    got.delete();
    repeat (7) @(negedge clk);
    hq = '{10, 10, 10};
    lq = '{15, 15, 15};
    drive_seq(1'b1);
    build_expected(1'b1);
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d pulses, need %0d", got.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_tests++;
        if (got[i].period !== exp_q[i].period || got[i].high !== exp_q[i].high) begin
          n_fail++;
          $display("FAIL midrst_value[%0d]: got %0d/%0d, need %0d/%0d", i,
                   got[i].period, got[i].high, exp_q[i].period, exp_q[i].high);
        end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    slow_in = 1'b0;
    test_reset();
    test_basic();
    test_random();
    test_period_at_timeout();
    test_period_over_timeout();
    test_timeout();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
